// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_sequencer
//  Description : Upstream controller for an 8:1 mux parallel-to-serial stage.
//                Accepts 8-bit words over a valid/ready handshake, holds the
//                word on `word`, and steps `sel` through all 8 positions (one
//                per unpaused cycle) with sof/eof framing and optional
//                inter-word gap cycles.
//  Parameters  : GAP_CYCLES - idle cycles after eof before next accept (0..15)
//                DIR        - 0: sel counts 0->7, 1: sel counts 7->0
//  Ports       : clk, rst (async, active-high)
//                in_valid/in_data/in_ready - upstream word handshake
//                hold      - pauses sel/count while shifting
//                word      - registered word feeding the mux data inputs
//                sel       - mux select
//                bit_valid - mux output carries a valid serial bit
//                sof/eof   - first/last bit strobes
//                busy      - not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_sequencer #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter bit          DIR        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       hold,
    output logic [7:0] word,
    output logic [2:0] sel,
    output logic       bit_valid,
    output logic       sof,
    output logic       eof,
    output logic       busy
);

    generate
        if (GAP_CYCLES > 15) begin : g_gap_range_err
            $error("mux_sel_sequencer: GAP_CYCLES must be in 0..15");
        end
    endgenerate

    localparam bit         c_NO_GAP   = (GAP_CYCLES == 0);
    localparam logic [3:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [3:0] r_gap_cnt;
    logic [3:0] w_gap_nxt;
    logic [7:0] r_word;

    logic       w_bit_valid;
    logic       w_eof;
    logic       w_ready;
    logic       w_xfer;

    assign w_bit_valid = (r_state == S_SHIFT) & ~hold;
    assign w_eof       = w_bit_valid & (r_cnt == 3'd7);
    // With no gap the next word may be taken on the eof edge, giving an
    // unbroken bit stream across words.
    assign w_ready     = ~rst & ((r_state == S_IDLE) | (c_NO_GAP & w_eof));
    assign w_xfer      = in_valid & w_ready;

    assign bit_valid = w_bit_valid;
    assign sof       = w_bit_valid & (r_cnt == 3'd0);
    assign eof       = w_eof;
    assign in_ready  = w_ready;
    assign busy      = (r_state != S_IDLE);
    assign sel       = DIR ? (3'd7 - r_cnt) : r_cnt;
    assign word      = r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_gap_cnt <= 4'd0;
            r_word    <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_nxt;
            // Only loaded on a transfer, so the word never changes mid-word.
            if (w_xfer) begin
                r_word <= in_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = 3'd0;
                end
            end
            S_SHIFT: begin
                if (!hold) begin
                    if (r_cnt != 3'd7) begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end else begin
                        w_cnt_nxt = 3'd0;
                        if (!c_NO_GAP) begin
                            w_state_nxt = S_GAP;
                            w_gap_nxt   = c_GAP_LOAD;
                        end else if (w_xfer) begin
                            w_state_nxt = S_SHIFT;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 3'd0;
                w_gap_nxt   = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
